// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and the
// helper that sizes the baud down-counter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    // Counter only has to hold CLK_DIV-1, so $clog2(CLK_DIV) bits are enough.
    function automatic int bit_cnt_width(input int clk_div);
        return (clk_div <= 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word; also used by the UART RX side.
// Push while full and pop while empty are silently ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && (level_q != (AW+1)'(DEPTH));
        do_pop   = pop && (level_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter: FIFO-buffered words are sent as start/data/parity/stop
// frames, LSB first, with every bit lasting exactly CLK_DIV clocks.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int CNT_W = bit_cnt_width(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;

    logic                 push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic [LVL_W-1:0]     level_next;
    logic                 bit_done;
    logic                 load;

    assign push = i_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        txd_d      = txd_q;
        load       = 1'b0;
        fifo_pop   = 1'b0;
        bit_done   = (cnt_q == '0);

        if (state_q != S_IDLE && !bit_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                load  = !fifo_empty;
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    txd_d   = shreg_q[0];
                    idx_d   = '0;
                    cnt_d   = CNT_RELOAD;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == IDX_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = S_STOP;
                            txd_d      = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                        txd_d   = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_idx_d = 1'b0;
                    cnt_d      = CNT_RELOAD;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more data waits.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        cnt_d      = CNT_RELOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            par_d    = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            state_d  = S_START;
            txd_d    = 1'b0;
            cnt_d    = CNT_RELOAD;
        end

        level_next = fifo_level + LVL_W'(push) - LVL_W'(fifo_pop);
        busy_d     = (state_d != S_IDLE) || (level_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign o_txd        = txd_q;
    assign o_busy       = busy_q;
    assign o_ready      = !fifo_full;
    assign o_fifo_level = fifo_level;

endmodule
